// File: rtl/pool_win_ctrl_if.sv
// pool_win_ctrl_if: pixel handshake, window flags and frame status between source and pool_win_ctrl
interface pool_win_ctrl_if #(parameter int CW = 8);
  logic start, in_valid, in_ready, dp_en, win_valid, out_valid, busy, done;
  logic [CW-1:0] out_row, out_col;
`ifdef POOL_WIN_CTRL_ABORT_EN
  logic abort;
  modport master(output start, in_valid, abort, input in_ready, dp_en, win_valid, out_valid, out_row, out_col, busy, done);
  modport slave(input start, in_valid, abort, output in_ready, dp_en, win_valid, out_valid, out_row, out_col, busy, done);
`else
  modport master(output start, in_valid, input in_ready, dp_en, win_valid, out_valid, out_row, out_col, busy, done);
  modport slave(input start, in_valid, output in_ready, dp_en, win_valid, out_valid, out_row, out_col, busy, done);
`endif
endinterface

// File: rtl/pool_win_ctrl.sv
// pool_win_ctrl: KxK stride-S pooling frame sequencer with LAT-aligned window flags (optional abort via POOL_WIN_CTRL_ABORT_EN)
module pool_win_ctrl #(
  parameter int D = 220,
  parameter int K = 3,
  parameter int S = 2,
  parameter int LAT = 3,
  parameter int CW = $clog2(D)
) (
  input logic clk,
  input logic reset,
  pool_win_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int LW = $clog2(LAT + 1);
  state_t state;
  logic [CW-1:0] row, col, rph, cph, wr, wc;
  logic [LW-1:0] dcnt;
  logic dv [LAT];
  logic [CW-1:0] dr [LAT];
  logic [CW-1:0] dc [LAT];
  logic kill, go, last, cwrap, row_ok, col_ok;
`ifdef POOL_WIN_CTRL_ABORT_EN
  assign kill = bus.abort & bus.busy;
`else
  assign kill = 1'b0;
`endif
  assign go = state == IDLE && bus.start;
  assign cwrap = col == CW'(D - 1);
  assign last = cwrap && row == CW'(D - 1);
  assign row_ok = row >= CW'(K - 1);
  assign col_ok = col >= CW'(K - 1);
  assign bus.dp_en = bus.in_valid & bus.in_ready;
  assign bus.win_valid = bus.dp_en & row_ok & col_ok & (rph == '0) & (cph == '0);
  assign bus.out_valid = dv[LAT-1];
  assign bus.out_row = dr[LAT-1];
  assign bus.out_col = dc[LAT-1];
  always_ff @(posedge clk)
    if (reset || kill) begin
      state <= IDLE;
      bus.in_ready <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      dcnt <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state <= RUN;
          bus.in_ready <= 1'b1;
          bus.busy <= 1'b1;
        end
        RUN: if (bus.dp_en && last) begin
          state <= DRAIN;
          bus.in_ready <= 1'b0;
          dcnt <= '0;
        end
        DRAIN: if (dcnt == LW'(LAT - 1)) begin
          state <= DONE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end else dcnt <= dcnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clk)
    if (reset || kill || go) begin
      row <= '0;
      col <= '0;
      rph <= '0;
      cph <= '0;
      wr <= '0;
      wc <= '0;
    end else if (bus.dp_en) begin
      col <= cwrap ? '0 : col + 1'b1;
      cph <= (cwrap || !col_ok || cph == CW'(S - 1)) ? '0 : cph + 1'b1;
      wc <= cwrap ? '0 : (col_ok && cph == CW'(S - 1)) ? wc + 1'b1 : wc;
      if (cwrap) begin
        row <= row + 1'b1;
        rph <= (!row_ok || rph == CW'(S - 1)) ? '0 : rph + 1'b1;
        wr <= (row_ok && rph == CW'(S - 1)) ? wr + 1'b1 : wr;
      end
    end
  always_ff @(posedge clk)
    if (reset || kill) begin
      for (int i = 0; i < LAT; i++) begin
        dv[i] <= 1'b0;
        dr[i] <= '0;
        dc[i] <= '0;
      end
    end else begin
      dv[0] <= bus.win_valid;
      dr[0] <= bus.win_valid ? wr : '0;
      dc[0] <= bus.win_valid ? wc : '0;
      for (int i = 1; i < LAT; i++) begin
        dv[i] <= dv[i-1];
        dr[i] <= dr[i-1];
        dc[i] <= dc[i-1];
      end
    end
endmodule
